// File: rtl/iob_bus_demux_pipe_pkg.sv
// Shared constants for the iob_bus_demux_pipe slice: select modes, the error
// read pattern and the outstanding-read counter width.
package iob_bus_demux_pipe_pkg;

  localparam int SEL_EXT  = 0;
  localparam int SEL_ADDR = 1;

  // Every bit of a timed-out read response carries this value.
  localparam logic RD_ERR_BIT = 1'b1;

  function automatic int cnt_w(input int max_rd);
    return $clog2(max_rd + 1);
  endfunction

endpackage

// File: rtl/iob_bus_demux_pipe_trk.sv
// Outstanding-read tracker: read count, owning follower, and the optional
// response timer enabled by IOB_BUS_DEMUX_PIPE_TIMEOUT_EN.
module iob_bus_demux_pipe_trk
  import iob_bus_demux_pipe_pkg::*;
#(
  parameter int NB     = 2,
  parameter int MAX_RD = 4,
  parameter int TMO_W  = 8
) (
  input  logic          clk_i,
  input  logic          cke_i,
  input  logic          rst_i,
  input  logic          rd_acc,
  input  logic [NB-1:0] sel,
  input  logic          rvalid_sel,
  output logic          cnt_nz,
  output logic          cnt_full,
  output logic [NB-1:0] cur_sel,
  output logic          tmo_rvalid,
  output logic          tmo_o
);

  localparam int CNT_W = cnt_w(MAX_RD);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NB-1:0]    cur_sel_reg;
  logic             dec;

  assign cnt_nz   = (cnt_reg != '0);
  assign cnt_full = (cnt_reg == CNT_W'(MAX_RD));
  assign cur_sel  = cur_sel_reg;

`ifdef IOB_BUS_DEMUX_PIPE_TIMEOUT_EN
  logic [TMO_W-1:0] tmr_reg;
  logic             tmo_reg;

  // A real response in the same cycle wins over the synthetic error response.
  assign tmo_rvalid = cnt_nz && !rvalid_sel && (&tmr_reg);
  assign tmo_o      = tmo_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_reg <= '0;
      tmo_reg <= 1'b0;
    end else if (cke_i) begin
      if (!cnt_nz || rvalid_sel || tmo_rvalid)
        tmr_reg <= '0;
      else
        tmr_reg <= tmr_reg + TMO_W'(1);
      if (tmo_rvalid)
        tmo_reg <= 1'b1;
    end
  end
`else
  assign tmo_rvalid = 1'b0;
  assign tmo_o      = 1'b0;
`endif

  assign dec = (rvalid_sel && cnt_nz) || tmo_rvalid;

  always_comb begin
    cnt_next = cnt_reg;
    if (rd_acc && !dec)
      cnt_next = cnt_reg + CNT_W'(1);
    else if (!rd_acc && dec)
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      cur_sel_reg <= '0;
    end else if (cke_i) begin
      cnt_reg <= cnt_next;
      if (rd_acc)
        cur_sel_reg <= sel;
    end
  end

endmodule

// File: rtl/iob_bus_demux_pipe.sv
// Pipelined IOb 1-to-N demux with outstanding-read tracking; optional response
// timeout via IOB_BUS_DEMUX_PIPE_TIMEOUT_EN (see iob_bus_demux_pipe_trk).
module iob_bus_demux_pipe
  import iob_bus_demux_pipe_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N        = 4,
  parameter int NB       = $clog2(N),
  parameter int SEL_MODE = SEL_EXT,
  parameter int MAX_RD   = 4,
  parameter int TMO_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    m_valid_i,
  input  logic [ADDR_W-1:0]       m_addr_i,
  input  logic [DATA_W-1:0]       m_wdata_i,
  input  logic [DATA_W/8-1:0]     m_wstrb_i,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic                    m_rvalid_o,
  output logic                    m_ready_o,
  output logic [N-1:0]            f_valid_o,
  output logic [N*ADDR_W-1:0]     f_addr_o,
  output logic [N*DATA_W-1:0]     f_wdata_o,
  output logic [N*DATA_W/8-1:0]   f_wstrb_o,
  input  logic [N*DATA_W-1:0]     f_rdata_i,
  input  logic [N-1:0]            f_rvalid_i,
  input  logic [N-1:0]            f_ready_i,
  input  logic [NB-1:0]           f_sel_i,
  output logic                    tmo_o
);

  localparam int SW = DATA_W / 8;

  logic [NB-1:0]     sel;
  logic [NB-1:0]     cur_sel;
  logic [N-1:0]      sel_oh, cur_oh;
  logic              unmapped, is_read, stall, open;
  logic              cnt_nz, cnt_full, rd_acc, rvalid_sel, tmo_rvalid;
  logic [DATA_W-1:0] rdata_mux;

  generate
    if (SEL_MODE == SEL_ADDR) begin : g_sel_addr
      assign sel = m_addr_i[ADDR_W-1 -: NB];
    end else begin : g_sel_ext
      assign sel = f_sel_i;
    end
  endgenerate

  assign unmapped = (int'(sel) >= N);
  assign is_read  = (m_wstrb_i == '0);
  // Switching followers waits for every pending read so responses stay ordered.
  assign stall    = (cnt_nz && (sel != cur_sel)) || (cnt_full && is_read) || unmapped;
  assign open     = !rst_i && !stall;

  assign m_ready_o  = open && |(f_ready_i & sel_oh);
  assign rd_acc     = m_valid_i && m_ready_o && is_read;
  assign rvalid_sel = |(f_rvalid_i & cur_oh);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_fan
      assign sel_oh[gi] = (sel == NB'(gi));
      assign cur_oh[gi] = (cur_sel == NB'(gi));
      assign f_valid_o[gi]                  = open && m_valid_i && sel_oh[gi];
      assign f_addr_o[gi*ADDR_W +: ADDR_W]  = m_addr_i;
      assign f_wdata_o[gi*DATA_W +: DATA_W] = m_wdata_i;
      assign f_wstrb_o[gi*SW +: SW]         = sel_oh[gi] ? m_wstrb_i : '0;
    end
  endgenerate

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N; i++)
      if (cur_oh[i])
        rdata_mux = rdata_mux | f_rdata_i[i*DATA_W +: DATA_W];
  end

  assign m_rvalid_o = !rst_i && ((rvalid_sel && cnt_nz) || tmo_rvalid);
  assign m_rdata_o  = tmo_rvalid ? {DATA_W{RD_ERR_BIT}} : rdata_mux;

  iob_bus_demux_pipe_trk #(
    .NB     (NB),
    .MAX_RD (MAX_RD),
    .TMO_W  (TMO_W)
  ) u_trk (
    .clk_i      (clk_i),
    .cke_i      (cke_i),
    .rst_i      (rst_i),
    .rd_acc     (rd_acc),
    .sel        (sel),
    .rvalid_sel (rvalid_sel),
    .cnt_nz     (cnt_nz),
    .cnt_full   (cnt_full),
    .cur_sel    (cur_sel),
    .tmo_rvalid (tmo_rvalid),
    .tmo_o      (tmo_o)
  );

endmodule
